// File: rtl/imem_loader.sv
// Program loader and writer side of the 16-word instruction memory.
// Holds the core in reset until a framed byte stream loads with a good checksum.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR   | expecting 0xA5 header byte
//   CNT   | expecting word count N (1..16)
//   HI    | expecting high byte of the next word
//   LO    | expecting low byte; writes the word
//   CHK   | expecting XOR checksum of all data bytes
//   DONE  | load good, core released from reset
//   ERR   | load failed, core held in reset
module imem_loader (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [3:0]  fetch_addr,
    output logic [15:0] fetch_data,
    output logic        core_resetn,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CNT,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] mem [DEPTH];
    logic [4:0]  wr_addr;
    logic [4:0]  cnt_n;
    logic [7:0]  xor_acc;
    logic [7:0]  hi_reg;

    logic        accept;
    logic        clr_load;
    logic        lat_cnt;
    logic        ld_hi;
    logic        wr_word;
    logic        last_word;

    assign busy        = (state == S_HDR) || (state == S_CNT) || (state == S_HI) ||
                         (state == S_LO)  || (state == S_CHK);
    assign rx_ready    = busy;
    assign done        = (state == S_DONE);
    assign err         = (state == S_ERR);
    assign core_resetn = (state == S_DONE);
    assign accept      = rx_valid && busy;
    assign last_word   = ((wr_addr + 5'd1) == cnt_n);
    assign fetch_data  = mem[fetch_addr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_load  = 1'b0;
        lat_cnt   = 1'b0;
        ld_hi     = 1'b0;
        wr_word   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_HDR;
                    clr_load  = 1'b1;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_nxt = (rx_data == 8'hA5) ? S_CNT : S_ERR;
                end
            end
            S_CNT: begin
                if (accept) begin
                    if ((rx_data >= 8'd1) && (rx_data <= 8'd16)) begin
                        state_nxt = S_HI;
                        lat_cnt   = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    state_nxt = S_LO;
                    ld_hi     = 1'b1;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_nxt = last_word ? S_CHK : S_HI;
                    wr_word   = 1'b1;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_nxt = (rx_data == xor_acc) ? S_DONE : S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load bookkeeping: count, address, running XOR and the pending high byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_addr <= '0;
            cnt_n   <= '0;
            xor_acc <= '0;
            hi_reg  <= '0;
        end else begin
            if (clr_load) begin
                wr_addr <= '0;
                xor_acc <= '0;
            end
            if (lat_cnt) begin
                cnt_n <= rx_data[4:0];
            end
            if (ld_hi) begin
                hi_reg  <= rx_data;
                xor_acc <= xor_acc ^ rx_data;
            end
            if (wr_word) begin
                xor_acc <= xor_acc ^ rx_data;
                wr_addr <= wr_addr + 5'd1;
            end
        end
    end

    // Memory clears on reset so an aborted load never leaves a partial program.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_word) begin
            mem[wr_addr[ADDR_W-1:0]] <= {hi_reg, rx_data};
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, stalls, reload and mid-load reset.
module tb_imem_loader;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  fetch_addr;
    logic [15:0] fetch_data;
    logic        core_resetn;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int ready_cycles = 0;

    imem_loader dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .core_resetn (core_resetn),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_ready) ready_cycles <= ready_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte and waits (bounded) for the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        logic taken;
        taken    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            taken = rx_ready;
            tick();
        end
        if (!taken) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_word(input int a, output logic [15:0] w);
        fetch_addr = a[3:0];
        #1;
        w = fetch_data;
    endtask

    logic [15:0] w;
    logic [7:0]  csum;
    logic [15:0] exp_words [16];
    int          zero_bad;

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        fetch_addr = 4'h0;
        #12;
        resetn = 1'b1;
        tick();

        // Reset state
        zero_bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_word(i, w);
            if (w !== 16'h0000) zero_bad++;
        end
        check("reset_mem_zero", zero_bad, 0);
        check("reset_core_resetn", core_resetn, 1'b0);
        check("reset_rx_ready", rx_ready, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);

        // Good 2-word frame, valid held high
        do_start();
        check("ready_after_start", rx_ready, 1'b1);
        ready_cycles = 0;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h40);
        rx_valid = 1'b0;
        check("good_ready_cycles", ready_cycles, 7);
        check("good_done", done, 1'b1);
        check("good_core_resetn", core_resetn, 1'b1);
        check("good_busy", busy, 1'b0);
        read_word(0, w); check("good_mem0", w, 16'h1234);
        read_word(1, w); check("good_mem1", w, 16'hABCD);
        zero_bad = 0;
        for (int i = 2; i < 16; i++) begin
            read_word(i, w);
            if (w !== 16'h0000) zero_bad++;
        end
        check("good_mem_rest_zero", zero_bad, 0);

        // Idle stall: no byte consumed in DONE
        rx_valid = 1'b1; rx_data = 8'hA5;
        tick(); tick();
        rx_valid = 1'b0;
        check("done_holds", done, 1'b1);

        // Reload from DONE with bad checksum
        do_start();
        check("reload_core_reset", core_resetn, 1'b0);
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h41);
        rx_valid = 1'b0;
        check("badsum_err", err, 1'b1);
        check("badsum_done", done, 1'b0);
        check("badsum_core_resetn", core_resetn, 1'b0);
        read_word(0, w); check("badsum_mem0", w, 16'h1234);

        // Bad header
        do_start();
        send_byte(8'h5A);
        rx_valid = 1'b0;
        check("badhdr_err", err, 1'b1);

        // Count 0
        do_start();
        send_byte(8'hA5);
        check("cnt0_not_err_yet", err, 1'b0);
        send_byte(8'h00);
        rx_valid = 1'b0;
        check("cnt0_err", err, 1'b1);

        // Count 17
        do_start();
        send_byte(8'hA5); send_byte(8'h11);
        rx_valid = 1'b0;
        check("cnt17_err", err, 1'b1);
        read_word(0, w); check("cnt_err_mem0", w, 16'h1234);
        read_word(1, w); check("cnt_err_mem1", w, 16'hABCD);
        read_word(2, w); check("cnt_err_mem2", w, 16'h0000);

        // Full 16-word frame with rx_valid toggling
        csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_words[i] = {8'h10 + 8'(i), 8'hF0 - 8'(i)};
            csum = csum ^ exp_words[i][15:8] ^ exp_words[i][7:0];
        end
        do_start();
        send_byte(8'hA5); rx_valid = 1'b0; tick();
        send_byte(8'h10); rx_valid = 1'b0; tick();
        for (int i = 0; i < 16; i++) begin
            send_byte(exp_words[i][15:8]); rx_valid = 1'b0; tick();
            send_byte(exp_words[i][7:0]);  rx_valid = 1'b0; tick();
        end
        check("full_busy_before_chk", busy, 1'b1);
        send_byte(csum);
        rx_valid = 1'b0;
        check("full_done", done, 1'b1);
        zero_bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_word(i, w);
            if (w !== exp_words[i]) zero_bad++;
        end
        check("full_words_bad", zero_bad, 0);
        read_word(0, w); check("full_mem0", w, 16'h10F0);
        read_word(15, w); check("full_mem15", w, 16'h1FE1);
        do_start();
        check("full_reload_core_reset", core_resetn, 1'b0);
        check("full_reload_busy", busy, 1'b1);

        // Mid-load reset after third data byte
        send_byte(8'hA5); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rx_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_core_resetn", core_resetn, 1'b0);
        zero_bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_word(i, w);
            if (w !== 16'h0000) zero_bad++;
        end
        check("rst_mem_zero", zero_bad, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("rst_idle_busy", busy, 1'b0);

        // Good load after reset
        do_start();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h51);
        rx_valid = 1'b0;
        check("post_rst_done", done, 1'b1);
        check("post_rst_core_resetn", core_resetn, 1'b1);
        read_word(0, w); check("post_rst_mem0", w, 16'hBEEF);
        read_word(1, w); check("post_rst_mem1", w, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and instruction-memory owner for the IITB RISC core. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes those words into a 16-entry instruction memory and holds the core in reset until a load completes with a good checksum. The fetch stage reads the same memory through an asynchronous read port, so this block is the writer side of the instruction memory that fetch reads.

## Interface
- DEPTH, 16, number of 16-bit instruction words (fixed; ADDR_W = 4)
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a load; honoured in IDLE, DONE or ERR only
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte this cycle
- fetch_addr  in  4  fetch-stage read address (PC[3:0])
- fetch_data  out  16  mem[fetch_addr], combinational
- core_resetn  out  1  active-low reset to the core; high only in DONE
- busy  out  1  high in HDR, CNT, HI, LO, CHK
- done  out  1  high in DONE
- err  out  1  high in ERR

## Operation
- Frame format: 0xA5 header, count byte N (1..16), then 2N data bytes (high byte then low byte per word), then a checksum byte equal to the XOR of all 2N data bytes.
- Byte accepted on a rising edge with rx_valid && rx_ready. rx_ready = busy. No byte is consumed in any other state.
- FSM states: IDLE, HDR, CNT, HI, LO, CHK, DONE, ERR.
  - IDLE/DONE/ERR + start -> HDR. The write address and running XOR clear to 0 on this transition.
  - HDR: accepted 0xA5 -> CNT; any other byte -> ERR.
  - CNT: accepted N with 1 <= N <= 16 -> HI, latching N; N = 0 or N > 16 -> ERR.
  - HI: accepted byte -> hi_reg, XOR updated -> LO.
  - LO: accepted byte -> mem[wr_addr] <= {hi_reg, rx_data}, XOR updated, wr_addr++.
    - If this was word N, next state is CHK; otherwise HI.
  - CHK: accepted byte == running XOR -> DONE; mismatch -> ERR.
  - DONE/ERR hold until start.
- start during HDR..CHK is ignored.
- Words not written by a load keep their previous contents. A failed load leaves any already-written words in memory, but the core stays in reset.
- wr_addr is a 5-bit count compared against N. The write index is wr_addr[3:0], so it never wraps within a legal frame.
- Write/read collision: if fetch_addr == write index in the write cycle, fetch_data shows the old word until the edge and the new word after it. The core is in reset during loads anyway.

## Timing
- Reset values:
  - state = IDLE
  - rx_ready = 0, busy = 0, done = 0, err = 0
  - core_resetn = 0
  - all 16 memory words = 0x0000
  - wr_addr = 0, XOR = 0x00, hi_reg = 0x00
- Reset asserted mid-load aborts immediately. The block returns to IDLE with memory cleared.
- start to first possible byte acceptance: 1 cycle (rx_ready rises the cycle after start is sampled).
- With rx_valid held high, a frame takes 2N+3 accepted cycles. done and core_resetn rise on the edge that accepts the checksum byte.
- core_resetn falls on the edge that samples start from DONE. The core re-enters reset for the whole reload.
- rx_valid low stalls the FSM in its current state with no side effects.
- fetch_data has zero-cycle latency from fetch_addr. A written word is visible the cycle after its LO byte is accepted.

## Test plan
- Reset, then idle: fetch_addr 0..15 -> fetch_data 0x0000 for all; core_resetn = 0; rx_ready = 0; done = err = 0.
- start, then bytes A5 02 12 34 AB CD 40 (XOR of 12 34 AB CD = 0x40), valid held high:
  - rx_ready high for 7 cycles.
  - mem[0] = 0x1234, mem[1] = 0xABCD, mem[2..15] = 0.
  - done = 1 and core_resetn = 1 after 7 accepted bytes.
- Same frame with checksum 0x41 -> err = 1, core_resetn stays 0, mem[0] = 0x1234 still readable.
- Header 0x5A -> ERR after 1 byte. Separately, count 0x00 or 0x11 -> ERR after 2 bytes; no memory word modified.
- Full 16-word frame with rx_valid toggling every other cycle: all 16 words correct, and wr_addr does not overwrite mem[0]. Then start from DONE: core_resetn drops next cycle.
- resetn pulsed low after the 3rd data byte of a load -> immediate IDLE, memory all zero, core_resetn = 0. A subsequent good load completes normally.
